i2c_target_regfile: RTL
=======================

# i2c_target_regfile

Synthesizable, clocked I2C target (slave) with a parametrised 7-bit address and an internal byte-wide register file of DEPTH entries. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It supports multi-byte register writes and reads with an auto-incrementing, wrapping register pointer. Register contents are exposed to the fabric via a write-notify strobe and a host read port, so the block sits between the board's open-drain I2C pins and local control logic.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit bus address the block responds to.
- DEPTH, 16, number of 8-bit registers; power of two, 2..256; AW = $clog2(DEPTH).
- SYNC_STAGES, 2, flops in each SCL/SDA input synchroniser (≥2).

- clk  in  1  system clock; must run ≥16× the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL pin input (asynchronous).
- sda_i  in  1  SDA pin input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad is open-drain, output value fixed 0).
- busy  out  1  high from an address-matched START until STOP.
- wr_valid  out  1  one-clk pulse per committed data byte.
- wr_addr  out  AW  register index of the committed byte.
- wr_data  out  8  committed byte value.
- host_raddr  in  AW  fabric read index.
- host_rdata  out  8  regs[host_raddr], registered, 1-clk latency.

## Operation
- Inputs pass through SYNC_STAGES flops plus one history flop. scl_rise, scl_fall, sda_rise and sda_fall come from the last two samples.
- START: sda_fall while SCL high in both samples. STOP: sda_rise while SCL high in both samples. START/STOP take priority over bit handling. A simultaneous SCL and SDA change is treated as an SCL edge only.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Any START (including repeated START) from any state → ADDR, with the bit counter cleared. STOP from any state → IDLE, sda_oe = 0, busy = 0. The pointer is preserved across both.
- ADDR: shift in 8 bits on scl_rise, MSB first.
  - If bits[7:1] == SLAVE_ADDR: → ADDR_ACK, drive ACK, set busy, latch rw = bit0.
  - Otherwise: → IGNORE, with sda_oe never asserted until the next START.
- ADDR_ACK: sda_oe = 1 from the 8th scl_fall to the 9th scl_fall. At the 9th fall, go to PTR if rw = 0, or RDATA if rw = 1.
- PTR: the first byte of a write is the pointer.
  - Value < DEPTH: load ptr, → PTR_ACK (ACK).
  - Value ≥ DEPTH: NACK (sda_oe stays 0), → IGNORE.
- WDATA: on the scl_rise sampling bit 8:
  - regs[ptr] ← byte
  - wr_valid = 1, wr_addr = ptr, wr_data = byte
  - ptr ← ptr+1 mod DEPTH
  - → WDATA_ACK (ACK driven for the 9th bit), then WDATA.
- RDATA:
  - At each scl_fall, drive sda_oe = ~shift[7]. The first bit is driven at the fall that ends the address ACK. shift loads regs[ptr].
  - After 8 bits, release at the 8th fall → RDATA_ACK.
  - Sample the master bit on the 9th scl_rise:
    - 0 (ACK): ptr ← ptr+1 mod DEPTH, reload shift, and drive the next MSB on the 9th fall.
    - 1 (NACK): ptr ← ptr+1, → IGNORE.
- host_rdata is always valid. A fabric read and an I2C write to the same index in the same clk returns the old value.

## Timing
- Reset values: sda_oe 0, busy 0, wr_valid 0, wr_addr 0, wr_data 0, host_rdata 0, ptr 0, all regs 0, state IDLE.
- Pin-to-decision latency is SYNC_STAGES+1 clk. sda_oe changes on the clk after the detected scl_fall, and must stay within tHD;DAT at the stated clk ratio.
- wr_valid is exactly one clk wide, asserted the clk after the detected 8th scl_rise of a data byte. The register write lands on the same edge.
- rst asserted mid-transaction: the next clk gives sda_oe = 0, state IDLE, and all regs cleared. The block then waits for a fresh START; it does not resume.
- Pointer wrap: DEPTH-1 → 0, for both reads and writes.
- START with no address match leaves busy at 0.

## Test plan
- Reset: hold rst 3 clk with random pins → all outputs 0. host_raddr = 5 gives host_rdata = 0 one clk later.
- Write burst: S, 0xA0, 0x03, 0x11, 0x22, P → ACK on all four bytes, and wr_valid pulses (3, 0x11) then (4, 0x22). host_raddr 3/4 → 0x11/0x22. busy falls at P.
- Wrap: S, 0xA0, 0x0F, 0xAA, 0xBB, P → regs[15] = 0xAA, regs[0] = 0xBB, and the final ptr is 1.
- Read with repeated START: S, 0xA0, 0x03, Sr, 0xA1 → SDA reads 0x11; master ACK; SDA reads 0x22; master NACK → sda_oe 0 until P, with no further drive.
- Mismatch/out-of-range:
  - S, 0xA2, 0x55, P → sda_oe never 1, no wr_valid, busy 0.
  - S, 0xA0, 0x10 → NACK, and later bytes are ignored.
- Reset mid-byte: rst for 1 clk during bit 4 of a write data byte → sda_oe 0, no wr_valid, regs cleared. The next full write transaction succeeds.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file behind an auto-incrementing pointer.
// SCL/SDA are oversampled on clk; START/STOP are detected from the synchronised samples.
module i2c_target_regfile #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         DEPTH       = 16,
   parameter int         SYNC_STAGES = 2,
   localparam int        AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   output logic          busy,
   output logic          wr_valid,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   input  logic [AW-1:0] host_raddr,
   output logic [7:0]    host_rdata
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   localparam logic [8:0] DEPTH9 = 9'(DEPTH);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_hist_q, sda_hist_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, sda_rise, sda_fall;
   logic                   start_det, stop_det;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [6:0]             sh_q, sh_d;
   logic                   rw_q, rw_d;
   logic [AW-1:0]          ptr_q, ptr_d;
   logic                   oe_q, oe_d;
   logic                   busy_q, busy_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [AW-1:0]          wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic [7:0]             host_rdata_q, host_rdata_d;
   logic [7:0]             regs_q [DEPTH];
   logic [7:0]             regs_d [DEPTH];
   logic                   we;
   logic [7:0]             rx_byte;
   logic [7:0]             rd_byte;

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_hist_q;
   assign scl_fall  = ~scl_s & scl_hist_q;
   assign sda_rise  = sda_s & ~sda_hist_q;
   assign sda_fall  = ~sda_s & sda_hist_q;
   // SCL must be stable high across both samples, so a coincident SCL edge wins.
   assign start_det = sda_fall & scl_s & scl_hist_q;
   assign stop_det  = sda_rise & scl_s & scl_hist_q;

   assign rx_byte = {sh_q, sda_s};
   assign rd_byte = regs_q[ptr_q];

   always_comb begin
      scl_sync_d   = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d   = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      host_rdata_d = regs_q[host_raddr];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      rw_d       = rw_q;
      ptr_d      = ptr_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      we         = 1'b0;
      if (start_det) begin
         state_d = ADDR;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE, IGNORE: ;
            ADDR: if (scl_rise) begin
               sh_d  = rx_byte[6:0];
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d = 4'd0;
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                     state_d = ADDR_ACK;
                     busy_d  = 1'b1;
                     rw_d    = rx_byte[0];
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            // cnt 0: waiting for the fall that starts the ACK bit; 1: the fall that ends it.
            ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
               if (cnt_q == 4'd0) begin
                  oe_d  = 1'b1;
                  cnt_d = 4'd1;
               end else begin
                  oe_d  = 1'b0;
                  cnt_d = 4'd0;
                  if (state_q == ADDR_ACK && rw_q) begin
                     state_d = RDATA;
                     sh_d    = rd_byte[6:0];
                     oe_d    = ~rd_byte[7];
                     cnt_d   = 4'd1;
                  end else if (state_q == ADDR_ACK) begin
                     state_d = PTR;
                  end else begin
                     state_d = WDATA;
                  end
               end
            end
            PTR: if (scl_rise) begin
               sh_d  = rx_byte[6:0];
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d = 4'd0;
                  if ({1'b0, rx_byte} < DEPTH9) begin
                     ptr_d   = rx_byte[AW-1:0];
                     state_d = PTR_ACK;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            WDATA: if (scl_rise) begin
               sh_d  = rx_byte[6:0];
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d      = 4'd0;
                  we         = 1'b1;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = rx_byte;
                  ptr_d      = ptr_q + 1'b1;
                  state_d    = WDATA_ACK;
               end
            end
            // The MSB went out with the previous fall; sh holds the remaining bits.
            RDATA: if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  oe_d    = 1'b0;
                  cnt_d   = 4'd0;
                  state_d = RDATA_ACK;
               end else begin
                  oe_d  = ~sh_q[6];
                  sh_d  = {sh_q[5:0], 1'b0};
                  cnt_d = cnt_q + 4'd1;
               end
            end
            RDATA_ACK: begin
               if (cnt_q == 4'd0) begin
                  if (scl_rise) begin
                     ptr_d = ptr_q + 1'b1;
                     if (sda_s) state_d = IGNORE;
                     else       cnt_d   = 4'd1;
                  end
               end else if (scl_fall) begin
                  sh_d    = rd_byte[6:0];
                  oe_d    = ~rd_byte[7];
                  cnt_d   = 4'd1;
                  state_d = RDATA;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[ptr_q] = rx_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q   <= '1;
         sda_sync_q   <= '1;
         scl_hist_q   <= 1'b1;
         sda_hist_q   <= 1'b1;
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         sh_q         <= 7'd0;
         rw_q         <= 1'b0;
         ptr_q        <= '0;
         oe_q         <= 1'b0;
         busy_q       <= 1'b0;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'd0;
         host_rdata_q <= 8'd0;
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'd0;
      end else begin
         scl_sync_q   <= scl_sync_d;
         sda_sync_q   <= sda_sync_d;
         scl_hist_q   <= scl_s;
         sda_hist_q   <= sda_s;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sh_q         <= sh_d;
         rw_q         <= rw_d;
         ptr_q        <= ptr_d;
         oe_q         <= oe_d;
         busy_q       <= busy_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         host_rdata_q <= host_rdata_d;
         regs_q       <= regs_d;
      end
   end

   assign sda_oe     = oe_q;
   assign busy       = busy_q;
   assign wr_valid   = wr_valid_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign host_rdata = host_rdata_q;

endmodule
